// File: rtl/fifo_pkg.sv
// fifo_pkg: shared count-width helper and fifo_status_t {full, empty, almost_full, almost_empty} for sync_fifo_fwft
package fifo_pkg;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: WIDTH x DEPTH register array; ports clock, reset_n (async low, clears to '0), we/waddr/wdata write, raddr -> rdata async read
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) mem <= '{default: '0};
    else if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: FWFT FIFO; ports clock, reset_n, flush, wr/data_in, rd/data_out, full, empty, almost_full, almost_empty, count, overflow/underflow/clr_err (live only with SYNC_FIFO_ERR_FLAGS_EN)
module sync_fifo_fwft
  import fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AF_MARGIN = 1,
  parameter int AE_MARGIN = 1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic                      wr,
  input  logic [WIDTH-1:0]          data_in,
  input  logic                      rd,
  output logic [WIDTH-1:0]          data_out,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  output logic                      underflow,
  input  logic                      clr_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr_ok, rd_ok;
  fifo_status_t st;
  assign st.full = count == CW'(DEPTH);
  assign st.empty = count == '0;
  assign st.almost_full = count >= CW'(DEPTH - AF_MARGIN);
  assign st.almost_empty = count <= CW'(AE_MARGIN);
  assign {full, empty, almost_full, almost_empty} = st;
  assign wr_ok = !flush && wr && (!st.full || rd);
  assign rd_ok = !flush && rd && !st.empty;
  fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clock(clock), .reset_n(reset_n), .we(wr_ok), .waddr(wr_ptr),
    .wdata(data_in), .raddr(rd_ptr), .rdata(data_out)
  );
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr_ok) - CW'(rd_ok);
    end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow <= (!flush && wr && st.full && !rd) || (overflow && !clr_err);
      underflow <= (!flush && rd && st.empty) || (underflow && !clr_err);
    end
`else
  logic unused_clr_err;
  assign unused_clr_err = clr_err;
  assign overflow = 1'b0;
  assign underflow = 1'b0;
`endif
endmodule

// File: tb/tb_sync_fifo_fwft.sv
// tb_sync_fifo_fwft: directed self-checking bench for sync_fifo_fwft (DEPTH=8, WIDTH=32)
module tb_sync_fifo_fwft;
  logic clock = 1'b0, reset_n = 1'b0, flush = 1'b0, wr = 1'b0, rd = 1'b0, clr_err = 1'b0;
  logic [31:0] data_in = '0, data_out;
  logic full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;
  int n_chk = 0, n_err = 0;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  localparam logic EF = 1'b1;
`else
  localparam logic EF = 1'b0;
`endif
  sync_fifo_fwft dut (
    .clock(clock), .reset_n(reset_n), .flush(flush), .wr(wr), .data_in(data_in),
    .rd(rd), .data_out(data_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );
  always #5 clock = ~clock;
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic push(input logic [31:0] v);
    wr = 1'b1;
    data_in = v;
    tick();
    wr = 1'b0;
  endtask
  task automatic clear_flags();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask
  int q[$];
  int nw, nr;
  logic dw, dr;
  initial begin
    #12;
    chk("rst_empty", empty, 1);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_count", count, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    reset_n = 1'b1;
    push(32'hA5A5_0001);
    chk("w1_empty", empty, 0);
    chk("w1_count", count, 1);
    chk("w1_dout", data_out, 32'hA5A5_0001);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("r1_empty", empty, 1);
    chk("r1_count", count, 0);
    for (int i = 0; i < 8; i++) begin
      push(32'h10 + i);
      chk("fill_count", count, i + 1);
      chk("fill_afull", almost_full, (i + 1) >= 7);
      chk("fill_full", full, (i + 1) == 8);
      chk("fill_aempty", almost_empty, (i + 1) <= 1);
    end
    push(32'hEE);
    chk("ovf_count", count, 8);
    chk("ovf_full", full, 1);
    chk("ovf_flag", overflow, EF);
    clear_flags();
    chk("ovf_clr", overflow, 0);
    rd = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_data", data_out, 32'h10 + i);
      tick();
    end
    rd = 1'b0;
    chk("drain_empty", empty, 1);
    for (int i = 0; i < 8; i++) push(32'h10 + i);
    wr = 1'b1;
    rd = 1'b1;
    data_in = 32'h99;
    for (int i = 0; i < 3; i++) begin
      chk("rw_full_data", data_out, 32'h10 + i);
      tick();
      chk("rw_full_full", full, 1);
      chk("rw_full_ovf", overflow, 0);
    end
    wr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("rw_drain", data_out, i < 5 ? 32'h13 + i : 32'h99);
      tick();
    end
    rd = 1'b0;
    chk("rw_drain_empty", empty, 1);
    wr = 1'b1;
    rd = 1'b1;
    data_in = 32'h55;
    tick();
    wr = 1'b0;
    rd = 1'b0;
    chk("unf_count", count, 1);
    chk("unf_flag", underflow, EF);
    chk("unf_dout", data_out, 32'h55);
    clear_flags();
    chk("unf_clr", underflow, 0);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("unf_pop_empty", empty, 1);
    nw = 0;
    nr = 0;
    for (int it = 0; it < 500 && nr < 20; it++) begin
      dr = q.size() > 0 && $urandom_range(0, 2) != 0;
      dw = nw < 20 && (q.size() < 8 || dr) && $urandom_range(0, 2) != 0;
      if (q.size() > 0) chk("wrap_data", data_out, q[0]);
      wr = dw;
      rd = dr;
      data_in = nw;
      tick();
      if (dr) void'(q.pop_front());
      if (dr) nr++;
      if (dw) q.push_back(nw);
      if (dw) nw++;
      chk("wrap_count", count, q.size());
    end
    wr = 1'b0;
    rd = 1'b0;
    chk("wrap_done", nr, 20);
    for (int i = 0; i < 5; i++) push(32'h70 + i);
    chk("mid_count", count, 5);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_count", count, 0);
    chk("async_empty", empty, 1);
    chk("async_dout", data_out, 0);
    chk("async_afull", almost_full, 0);
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) push(32'h80 + i);
    flush = 1'b1;
    wr = 1'b1;
    data_in = 32'hDD;
    tick();
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    chk("flush_ovf", overflow, 0);
    rd = 1'b1;
    tick();
    flush = 1'b0;
    wr = 1'b0;
    rd = 1'b0;
    chk("flush2_count", count, 0);
    chk("flush2_unf", underflow, 0);
    push(32'h42);
    chk("post_flush_dout", data_out, 32'h42);
    chk("post_flush_count", count, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/sync_fifo_fwft.md
# sync_fifo_fwft

Parametrised synchronous first-word-fall-through FIFO for buffering 32-bit (default) packets between producer and consumer stages on a single clock domain. Generalises the single-depth packet FIFO with configurable width and depth, same-cycle read and write at every fill level, almost-full/almost-empty thresholds, a fill-level output, synchronous flush, and optional sticky overflow/underflow error flags. Drop-in buffer between pipeline stages that need backpressure.

## Interface
- `WIDTH`, 32, data word width in bits (≥1)
- `DEPTH`, 8, number of entries; power of two, ≥2
- `AF_MARGIN`, 1, almost_full asserts when free slots ≤ AF_MARGIN (0 ≤ AF_MARGIN < DEPTH)
- `AE_MARGIN`, 1, almost_empty asserts when count ≤ AE_MARGIN (0 ≤ AE_MARGIN < DEPTH)

- `clock`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `flush`  in  1  synchronous clear of contents; priority over wr/rd
- `wr`  in  1  write request
- `data_in`  in  WIDTH  write data
- `rd`  in  1  read (pop) request; acknowledges the word currently on data_out
- `data_out`  out  WIDTH  head-of-queue word; valid while !empty
- `full`  out  1  count == DEPTH
- `empty`  out  1  count == 0
- `almost_full`  out  1  count ≥ DEPTH − AF_MARGIN
- `almost_empty`  out  1  count ≤ AE_MARGIN
- `count`  out  $clog2(DEPTH+1)  current fill level
- `overflow`  out  1  sticky: write attempted while full and no read accepted in the same cycle
- `underflow`  out  1  sticky: read attempted while empty
- `clr_err`  in  1  synchronous clear of overflow/underflow

## Operation
- State: storage array DEPTH×WIDTH, wr_ptr and rd_ptr of $clog2(DEPTH) bits (natural wrap at DEPTH), count register.
- Accepted write: wr_ok = wr && (!full || rd). Accepted read: rd_ok = rd && !empty.
- wr_ok: mem[wr_ptr] ← data_in; wr_ptr += 1. rd_ok: rd_ptr += 1.
- count += wr_ok − rd_ok; both accepted → count unchanged.
- Full, rd && wr: both accepted; stays full; written word lands in the slot freed by the read.
- Empty, rd && wr: write accepted, read rejected; underflow set; count → 1.
- data_out = mem[rd_ptr] (FWFT: head is presented without a prior rd). While empty, data_out holds the stale entry at rd_ptr and is not valid.
- flush: wr_ptr, rd_ptr and count → 0 at the edge; wr/rd that cycle are ignored and set no error flags; storage is not cleared.
- Error flags set on the violating edge and hold until clr_err or reset; clr_err and a new violation in the same cycle → flag stays set.
- Reset (asynchronous, any time including mid-burst): pointers, count, error flags → 0, storage → '0; empty=1, almost_empty=1, full=0, almost_full=0 (AF_MARGIN < DEPTH), data_out='0.

## Timing
- Write-to-read latency 1 cycle: word written at edge N appears on data_out, with empty=0, after edge N.
- rd_ok at edge N: next word is on data_out after edge N.
- Status outputs (full, empty, almost_*) decode combinationally from the registered count only. No combinational path from any input to any output.
- Sustained 1 word/cycle throughput in both directions at every fill level.

## Configuration
- `SYNC_FIFO_ERR_FLAGS_EN` defined: overflow/underflow sticky registers and clr_err operate as above.
- Not defined: overflow and underflow are tied 0, clr_err is ignored, and no error registers are built. Rejected accesses are still dropped silently.

## Structure
- Package `fifo_pkg`: count-width helper function (clog2 of DEPTH+1) and a `fifo_status_t` packed struct {full, empty, almost_full, almost_empty}.
- Sub-module `fifo_mem`: WIDTH×DEPTH register array with write port (we, waddr, wdata), asynchronous read port (raddr → rdata), and async reset to '0. Top level holds pointers, count, flags and the accept logic.

## Test plan
- Reset, then write 0xA5A5_0001 with no rd → after 1 edge empty=0, count=1, data_out=0xA5A5_0001. Pop → empty=1, count=0.
- DEPTH=8: write 0x10..0x17 → full=1 after 8th edge, almost_full=1 from count=7. 9th wr alone → data dropped, overflow=1, count=8. Drain → 0x10..0x17 in order.
- Fill to 8, then assert rd&&wr with 0x99 for 3 cycles → full stays 1, outputs 0x10,0x11,0x12, later tail 0x99 ×3.
- Empty, rd&&wr with 0x55 → count=1, underflow=1, data_out=0x55. Pulse clr_err → underflow=0.
- Wrap: 20 write/read pairs (0..19) interleaved at random fill levels 0..8 → output sequence 0..19, count matches the model every cycle.
- Fill to 5, assert reset_n=0 mid-cycle between edges → outputs reset immediately. Separately, with flush and wr both asserted → count=0, empty=1, no flag set.
